// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and default sizes for the memory arbiter
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_MAX_LS_BURST = 4;

  // Encodes which port owns the read data returning next cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_LS = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - one-hot grant select: load/store first unless fetch has waited a full burst
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_LS_BURST = DEF_MAX_LS_BURST,
  parameter int unsigned STREAK_W     = $clog2(MAX_LS_BURST) + 1
) (
  input  logic                rst,
  input  logic                if_req,
  input  logic                ls_req,
  input  logic [STREAK_W-1:0] ls_streak,
  output logic                if_gnt,
  output logic                ls_gnt
);

  logic starved;

  always_comb begin
    starved = if_req && (ls_streak == STREAK_W'(MAX_LS_BURST));
    ls_gnt  = rst && ls_req && !starved;
    if_gnt  = rst && if_req && !(ls_req && !starved);
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port synchronous memory between fetch and load/store ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MAX_LS_BURST = DEF_MAX_LS_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned       STREAK_W  = $clog2(MAX_LS_BURST) + 1;
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] ls_streak_q, ls_streak_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

  mem_arb_pick #(
    .MAX_LS_BURST(MAX_LS_BURST),
    .STREAK_W    (STREAK_W)
  ) u_pick (
    .rst      (rst),
    .if_req   (if_req),
    .ls_req   (ls_req),
    .ls_streak(ls_streak_q),
    .if_gnt   (if_gnt),
    .ls_gnt   (ls_gnt)
  );

  always_comb begin
    state_d     = IDLE;
    ls_streak_d = ls_streak_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    if (if_gnt) begin
      state_d = RD_IF;
    end else if (ls_gnt && !ls_we) begin
      state_d = RD_LS;
    end

    // Streak only counts load/store wins while a fetch is actually waiting
    if (!if_req || if_gnt) begin
      ls_streak_d = '0;
    end else if (ls_gnt) begin
      ls_streak_d = ls_streak_q + STREAK_W'(1);
    end

    if (ls_gnt) begin
      mem_en   = 1'b1;
      mem_we   = ls_we;
      mem_addr = ls_addr & WORD_MASK;
      if (ls_we) begin
        mem_wdata = ls_wdata;
      end
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr & WORD_MASK;
    end

    // Gating with rst drops a read that was in flight when reset arrived
    if_rvalid  = rst && (state_q == RD_IF);
    ls_rvalid  = rst && (state_q == RD_LS);
    if_rdata   = if_rvalid ? mem_rdata : if_rdata_q;
    ls_rdata   = ls_rvalid ? mem_rdata : ls_rdata_q;
    if_rdata_d = if_rdata;
    ls_rdata_d = ls_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ls_streak_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      ls_streak_q <= ls_streak_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural one-cycle memory
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_gnt   (ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata (ls_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? memf(mem_addr) : 32'h0;
  end

  // Response monitor: pops the scoreboard on every rvalid, checks hold otherwise
  always begin
    logic rst_s;
    exp_t e;
    @(posedge clk);
    rst_s = rst;
    #2;
    if (!rst_s) begin
      last_if = '0;
      last_ls = '0;
    end
    checks++;
    if (if_rvalid || ls_rvalid) begin
      if (if_rvalid && ls_rvalid) begin
        failures++;
        $display("FAIL dual_rvalid got if=%0b ls=%0b required one", if_rvalid, ls_rvalid);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid got if=%0b ls=%0b required none", if_rvalid, ls_rvalid);
      end else begin
        e = sb.pop_front();
        if (e.is_if !== if_rvalid || (if_rvalid ? if_rdata : ls_rdata) !== e.data) begin
          failures++;
          $display("FAIL rdata got if_rvalid=%0b data=%h required is_if=%0b data=%h",
                   if_rvalid, if_rvalid ? if_rdata : ls_rdata, e.is_if, e.data);
        end
        if (if_rvalid) last_if = if_rdata;
        else last_ls = ls_rdata;
      end
    end else if (if_rdata !== last_if || ls_rdata !== last_ls) begin
      failures++;
      $display("FAIL rdata_hold got if=%h ls=%h required if=%h ls=%h",
               if_rdata, ls_rdata, last_if, last_ls);
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b1;
    ls_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_gate got gnt/en/we=%b required 0000", {if_gnt, ls_gnt, mem_en, mem_we});
    end
    @(negedge clk);
    if_req = 1'b0;
    ls_req = 1'b0;
    #1;
    checks++;
    if ({if_rvalid, ls_rvalid} !== 2'b00 || if_rdata !== 32'h0 || ls_rdata !== 32'h0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got rv=%b if_rdata=%h ls_rdata=%h addr=%h required zeros",
               {if_rvalid, ls_rvalid}, if_rdata, ls_rdata, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h0000_0104;
    #1;
    checks++;
    if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h0000_0104 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL fetch_grant got gnt/en/we=%b addr=%h wdata=%h required 1010 addr=00000104 wdata=0",
               {if_gnt, ls_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    sb.push_back('{1'b1, memf(32'h0000_0104)});
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++;
    if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_outputs got gnt/en/we=%b required 0000", {if_gnt, ls_gnt, mem_en, mem_we});
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h0000_0200;
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    #1;
    checks++;
    if ({if_gnt, ls_gnt} !== 2'b01 || mem_addr !== 32'h0000_0200 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL priority_ls got if/ls=%b addr=%h we=%b required 01 addr=00000200 we=0",
               {if_gnt, ls_gnt}, mem_addr, mem_we);
    end
    sb.push_back('{1'b0, memf(32'h0000_0200)});
    @(negedge clk);
    ls_req = 1'b0;
    #1;
    checks++;
    if ({if_gnt, ls_gnt} !== 2'b10 || mem_addr !== 32'h0000_0010) begin
      failures++;
      $display("FAIL priority_if_next got if/ls=%b addr=%h required 10 addr=00000010",
               {if_gnt, ls_gnt}, mem_addr);
    end
    sb.push_back('{1'b1, memf(32'h0000_0010)});
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic test_starvation();
    bit exp_ls[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h0000_0300;
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++;
      if (ls_gnt !== exp_ls[i] || if_gnt !== !exp_ls[i]) begin
        failures++;
        $display("FAIL starve_cycle%0d got if/ls=%b%b required %b%b", i, if_gnt, ls_gnt, !exp_ls[i], exp_ls[i]);
      end
      sb.push_back('{!exp_ls[i], exp_ls[i] ? memf(32'h0000_0300) : memf(32'h0000_0040)});
    end
    @(negedge clk);
    ls_req = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic test_store();
    @(negedge clk);
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h0000_0203;
    ls_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({ls_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 32'h0000_0200 || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store got gnt/en/we=%b addr=%h wdata=%h required 111 addr=00000200 wdata=deadbeef",
               {ls_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    ls_req = 1'b0;
    ls_we  = 1'b0;
    #1;
    checks++;
    if (ls_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL store_rvalid got %b required 0", ls_rvalid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ls_req  = 1'b1;
    ls_addr = 32'h0000_0080;
    #1;
    sb.push_back('{1'b0, memf(32'h0000_0080)});
    @(negedge clk);
    ls_req  = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0086;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || ls_rvalid !== 1'b1 || mem_addr !== 32'h0000_0084) begin
      failures++;
      $display("FAIL b2b_overlap got if_gnt=%b ls_rvalid=%b addr=%h required 1 1 addr=00000084",
               if_gnt, ls_rvalid, mem_addr);
    end
    sb.push_back('{1'b1, memf(32'h0000_0084)});
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h0000_0400;
    #1;
    checks++;
    if (ls_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rst_load_grant got %b required 1", ls_gnt);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    ls_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (ls_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_rvalid got %b required 0", ls_rvalid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({if_gnt, ls_gnt, mem_en, mem_we, if_rvalid, ls_rvalid} !== 6'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_outputs got flags=%b addr=%h wdata=%h if_rdata=%h ls_rdata=%h required zeros",
               {if_gnt, ls_gnt, mem_en, mem_we, if_rvalid, ls_rvalid}, mem_addr, mem_wdata, if_rdata, ls_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_store();
    test_back_to_back();
    test_reset_mid_read();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_rvalid got pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
